// File: rtl/ram_port0_arbiter_if.sv
// ram_port0_arbiter_if: single-word command/response channel between a bus master and the port-0 arbiter.
interface ram_port0_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    valid;
  logic                    ready;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  modport master(output valid, we, wmask, addr, wdata, input ready, rvalid, rdata);
  modport slave(input valid, we, wmask, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/ram_port0_arbiter.sv
// ram_port0_arbiter: round-robin arbiter and sequencer for SRAM port 0 serving two requesters.
module ram_port0_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk0,
  input  logic                    rst0,
  ram_port0_arbiter_if.slave      m0,
  ram_port0_arbiter_if.slave      m1,
  output logic                    csb0,
  output logic                    web0,
  output logic [DATA_WIDTH/8-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0]   addr0,
  output logic [DATA_WIDTH-1:0]   din0,
  input  logic [DATA_WIDTH-1:0]   dout0
);
  localparam int MW = DATA_WIDTH / 8;
  logic                  ptr;
  logic                  g0, g1, acc, we;
  logic [MW-1:0]         mask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0]            tag_v, tag_id;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  always_comb begin
    g0 = !rst0 && m0.valid && (!m1.valid || !ptr);
    g1 = !rst0 && m1.valid && (!m0.valid || ptr);
    acc = g0 || g1;
    we = g1 ? m1.we : m0.we;
    mask = g1 ? m1.wmask : m0.wmask;
    addr = g1 ? m1.addr : m0.addr;
    wdata = g1 ? m1.wdata : m0.wdata;
  end
  assign m0.ready = g0;
  assign m1.ready = g1;
  // Tag stage 1 marks the cycle dout0 is valid; stage 2 is the response cycle.
  assign m0.rvalid = tag_v[2] && !tag_id[2];
  assign m1.rvalid = tag_v[2] && tag_id[2];
  assign m0.rdata = rdata0;
  assign m1.rdata = rdata1;
  always_ff @(posedge clk0) begin
    if (rst0) begin
      ptr <= 1'b0;
      csb0 <= 1'b1;
      web0 <= 1'b1;
      wmask0 <= '0;
      addr0 <= '0;
      din0 <= '0;
      tag_v <= '0;
      tag_id <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ptr <= g0 ? 1'b1 : g1 ? 1'b0 : ptr;
      csb0 <= !acc;
      web0 <= !(acc && we);
      if (acc) begin
        addr0 <= addr;
        wmask0 <= we ? mask : '0;
        din0 <= we ? wdata : '0;
      end
      tag_v <= {tag_v[1:0], acc && !we};
      tag_id <= {tag_id[1:0], g1};
      if (tag_v[1] && !tag_id[1]) rdata0 <= dout0;
      if (tag_v[1] && tag_id[1]) rdata1 <= dout0;
    end
  end
endmodule
